lut_neuron_prog_loader: RTL and testbench

//   Runtime-programmable LUT neuron: the write side of our fixed truth-table neurons.
//   - Receives a neuron truth table as a stream of beats and stores it in distributed RAM.
//   - Answers registered lookups against the stored table.

---
 rtl/lut_neuron_prog_loader.sv | 124 ++++++++++++
 tb/tb_lut_neuron_prog_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_prog_loader.sv
// Runtime-loadable truth-table neuron: streams a table into distributed RAM
// and serves single-cycle registered lookups once a complete table is held.
module lut_neuron_prog_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LOAD_W-1:0]   cfg_data,
    output logic                cfg_done,
    output logic                tbl_valid,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                q_drop
);

    localparam int DEPTH  = 1 << IN_BITS;
    localparam int EPB    = LOAD_W / OUT_BITS;
    localparam int BEATS  = DEPTH / EPB;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EPB_SH = $clog2(EPB);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                tbl_valid_nx;
    logic                done_nx;
    logic                wr_en;
    logic [IN_BITS-1:0]  wr_base;

    logic [OUT_BITS-1:0] tbl_ram [DEPTH];

    logic                vld_p1;
    logic                drop_p1;
    logic [OUT_BITS-1:0] data_p1;

    // Control FSM: registered state, counter, table-valid flag and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tbl_valid <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tbl_valid <= tbl_valid_nx;
            cfg_done  <= done_nx;
        end
    end

    // A start pulse always wins over a beat in the same cycle, including the last one
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        tbl_valid_nx = tbl_valid;
        done_nx      = 1'b0;
        wr_en        = 1'b0;
        cfg_ready    = (state == LOAD);
        case (state)
            LOAD: begin
                if (cfg_start) begin
                    cnt_nx = '0;
                end else if (cfg_valid) begin
                    wr_en = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_nx     = READY;
                        tbl_valid_nx = 1'b1;
                        done_nx      = 1'b1;
                        cnt_nx       = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (cfg_start) begin
                    state_nx     = LOAD;
                    tbl_valid_nx = 1'b0;
                    cnt_nx       = '0;
                end
            end
        endcase
    end

    // EPB is a power of two, so the beat's base entry is a plain shift of the counter
    assign wr_base = IN_BITS'(cnt) << EPB_SH;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < EPB; j++) begin
                tbl_ram[wr_base | IN_BITS'(j)] <= cfg_data[j*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Lookup stage p1: result registered one cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            drop_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= in_valid & tbl_valid;
            drop_p1 <= in_valid & ~tbl_valid;
            if (in_valid && tbl_valid) begin
                data_p1 <= tbl_ram[in_data];
            end
        end
    end

    assign out_valid = vld_p1;
    assign q_drop    = drop_p1;
    assign out_data  = data_p1;

endmodule

// File: tb/tb_lut_neuron_prog_loader.sv
// Bench for lut_neuron_prog_loader: table loads, restarts, reset mid-load and
// lookups checked against a bench-side table model through a scoreboard queue.
module tb_lut_neuron_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       cfg_done;
    logic       tbl_valid;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [0:0] out_data;
    logic       q_drop;

    typedef struct packed {
        logic vld;
        logic drop;
        logic data;
    } exp_t;

    exp_t       sb[$];
    logic       model [256];
    logic [7:0] beat_buf [32];
    logic       tv_model;
    logic       last_out;
    int         n_vec;
    int         n_err;

    lut_neuron_prog_loader #(.IN_BITS(8), .OUT_BITS(1), .LOAD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .tbl_valid (tbl_valid),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .q_drop    (q_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue n lookups on consecutive cycles; each expectation is queued when driven
    // and popped when the registered result appears.
    task automatic run_lookups(input int base, input int n, input int stride, output int nvld);
        exp_t e;
        logic [7:0] a;
        nvld = 0;
        for (int i = 0; i < n; i++) begin
            a = 8'(base + i * stride);
            in_valid = 1'b1;
            in_data  = a;
            if (tv_model) begin
                e.vld = 1'b1; e.drop = 1'b0; e.data = model[a];
                last_out = model[a];
            end else begin
                e.vld = 1'b0; e.drop = 1'b1; e.data = last_out;
            end
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_vec++;
            if (out_valid !== e.vld || q_drop !== e.drop || out_data[0] !== e.data) begin
                n_err++;
                $display("FAIL lookup addr=%02h: got vld=%b drop=%b data=%b, want vld=%b drop=%b data=%b",
                         a, out_valid, q_drop, out_data, e.vld, e.drop, e.data);
            end
            if (out_valid === 1'b1) nvld++;
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || q_drop !== 1'b0) begin
            n_err++;
            $display("FAIL lookup_idle: got vld=%b drop=%b, want 0 0", out_valid, q_drop);
        end
    endtask

    task automatic do_load(input bit gaps);
        int ndone;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        tv_model  = 1'b0;
        n_vec++;
        if (tbl_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_start: got tbl_valid=%b cfg_ready=%b, want 0 1", tbl_valid, cfg_ready);
        end
        ndone = 0;
        for (int k = 0; k < 32; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    cfg_valid = 1'b0;
                    cfg_data  = 8'($urandom);
                    step();
                    if (cfg_done === 1'b1) ndone++;
                end
            end
            cfg_valid = 1'b1;
            cfg_data  = beat_buf[k];
            step();
            if (cfg_done === 1'b1) ndone++;
            if (k < 31) begin
                n_vec++;
                if (tbl_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL tbl_valid_in_load beat=%0d: got %b, want 0", k, tbl_valid);
                end
            end
        end
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_done !== 1'b1 || tbl_valid !== 1'b1 || cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_end: got done=%b tbl_valid=%b ready=%b, want 1 1 0",
                     cfg_done, tbl_valid, cfg_ready);
        end
        step();
        if (cfg_done === 1'b1) ndone++;
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses, want 1", ndone);
        end
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 8; j++)
                model[k*8 + j] = beat_buf[k][j];
        tv_model = 1'b1;
    endtask

    task automatic test_reset();
        int nv;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        n_vec++;
        if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || tbl_valid !== 1'b0 ||
            out_valid !== 1'b0 || out_data !== 1'b0 || q_drop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b done=%b tv=%b ov=%b od=%b drop=%b, want all 0",
                     cfg_ready, cfg_done, tbl_valid, out_valid, out_data, q_drop);
        end
        run_lookups(8'h05, 1, 1, nv);
    endtask

    task automatic test_load();
        int nv;
        for (int k = 0; k < 32; k++) beat_buf[k] = 8'(k);
        do_load(1'b0);
        run_lookups(8'h08, 1, 1, nv);
        run_lookups(8'h09, 1, 1, nv);
        run_lookups(8'hFD, 1, 1, nv);
    endtask

    task automatic test_gapped();
        int nv;
        for (int k = 0; k < 32; k++) beat_buf[k] = 8'(k);
        do_load(1'b1);
        run_lookups(0, 64, 4, nv);
    endtask

    task automatic test_restart();
        int nv;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        tv_model  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'hFF;
            step();
            n_vec++;
            if (tbl_valid !== 1'b0 || cfg_done !== 1'b0) begin
                n_err++;
                $display("FAIL partial_load beat=%0d: got tv=%b done=%b, want 0 0", k, tbl_valid, cfg_done);
            end
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < 32; k++) beat_buf[k] = 8'h00;
        do_load(1'b0);
        run_lookups(0, 256, 1, nv);
    endtask

    task automatic test_rst_mid_load();
        int nv;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        tv_model  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            step();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_out = 1'b0;
        n_vec++;
        if (tbl_valid !== 1'b0 || cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_load: got tv=%b ready=%b done=%b, want 0 0 0", tbl_valid, cfg_ready, cfg_done);
        end
        run_lookups(8'h33, 1, 1, nv);
        for (int k = 0; k < 32; k++) beat_buf[k] = 8'($urandom);
        do_load(1'b1);
        run_lookups(3, 40, 7, nv);
    endtask

    task automatic test_back_to_back();
        int   nv;
        exp_t e;
        run_lookups(0, 256, 1, nv);
        n_vec++;
        if (nv != 256) begin
            n_err++;
            $display("FAIL b2b_valid_count: got %0d, want 256", nv);
        end
        // beats while READY must not touch the table
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'hA5 ^ 8'(k);
            step();
        end
        cfg_valid = 1'b0;
        run_lookups(0, 256, 1, nv);
        // lookup in the start cycle still sees the old table
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        e.vld = 1'b1; e.drop = 1'b0; e.data = model[8'h11];
        last_out = model[8'h11];
        sb.push_back(e);
        step();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        tv_model  = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== e.vld || q_drop !== e.drop || out_data[0] !== e.data) begin
            n_err++;
            $display("FAIL start_cycle_lookup: got vld=%b drop=%b data=%b, want %b %b %b",
                     out_valid, q_drop, out_data, e.vld, e.drop, e.data);
        end
        for (int k = 0; k < 31; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            step();
        end
        cfg_start = 1'b1;
        cfg_data  = 8'h5A;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_done !== 1'b0 || tbl_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_with_last: got done=%b tv=%b ready=%b, want 0 0 1", cfg_done, tbl_valid, cfg_ready);
        end
        step();
        n_vec++;
        if (cfg_done !== 1'b0 || tbl_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_with_last_after: got done=%b tv=%b, want 0 0", cfg_done, tbl_valid);
        end
        run_lookups(8'h05, 2, 1, nv);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        tv_model  = 1'b0;
        last_out  = 1'b0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        test_reset();
        test_load();
        test_gapped();
        test_restart();
        test_rst_mid_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
